// File: rtl/id_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : id_pkg                                                     |
// | Description : Shared constants for the instruction-decode stage: default |
// |               datapath/register-address widths and the register-field    |
// |               offsets inside a 32-bit instruction word.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package id_pkg;

  localparam int c_XLEN    = 32;
  localparam int c_RA_W    = 5;
  localparam int c_INSTR_W = 32;
  localparam int c_RS_LSB  = 21;
  localparam int c_RT_LSB  = 16;

endpackage : id_pkg
`default_nettype wire

// File: rtl/id_stage_fwd_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : id_stage_fwd_if                                            |
// | Description : Pipeline handshake (IF->ID, ID->EXE) and the packed        |
// |               forwarding-source bus seen by the decode stage.            |
// |   master : drives IF payload, exe_allowin and the fwd_* bus              |
// |   slave  : the ID stage; drives id_allowin, id_exe_validto, id_valid,    |
// |            pc_out, instr_out                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface id_stage_fwd_if
  import id_pkg::*;
#(
  parameter int XLEN  = c_XLEN,
  parameter int RA_W  = c_RA_W,
  parameter int N_FWD = 3
);

  // IF -> ID
  logic                  if_id_validto;
  logic [XLEN-1:0]       pc_in;
  logic [c_INSTR_W-1:0]  instr_in;
  logic                  id_allowin;

  // ID -> EXE
  logic                  exe_allowin;
  logic                  id_exe_validto;
  logic                  id_valid;
  logic [XLEN-1:0]       pc_out;
  logic [c_INSTR_W-1:0]  instr_out;

  // Forwarding sources, index 0 = youngest
  logic [N_FWD-1:0]      fwd_valid;
  logic [N_FWD*RA_W-1:0] fwd_rdc;
  logic [N_FWD*XLEN-1:0] fwd_data;
  logic [N_FWD-1:0]      fwd_ready;

  modport master (
    output if_id_validto, pc_in, instr_in, exe_allowin,
           fwd_valid, fwd_rdc, fwd_data, fwd_ready,
    input  id_allowin, id_exe_validto, id_valid, pc_out, instr_out
  );

  modport slave (
    input  if_id_validto, pc_in, instr_in, exe_allowin,
           fwd_valid, fwd_rdc, fwd_data, fwd_ready,
    output id_allowin, id_exe_validto, id_valid, pc_out, instr_out
  );

endinterface : id_stage_fwd_if
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fwd_select                                                 |
// | Description : Resolves one source operand against N_FWD forwarding       |
// |               sources; the youngest (lowest index) matching source wins. |
// | Ports:                                                                   |
// |   addr, used         : register read address and decoder use flag        |
// |   fwd_valid/rdc/data/ready : packed forwarding bus                       |
// |   rf_rdata           : register-file value used when nothing matches     |
// |   value              : resolved operand                                  |
// |   hit                : some source matched                               |
// |   not_ready          : the selected source has no data yet               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fwd_select
  import id_pkg::*;
#(
  parameter int XLEN  = c_XLEN,
  parameter int RA_W  = c_RA_W,
  parameter int N_FWD = 3
) (
  input  logic [RA_W-1:0]       addr,
  input  logic                  used,
  input  logic [N_FWD-1:0]      fwd_valid,
  input  logic [N_FWD*RA_W-1:0] fwd_rdc,
  input  logic [N_FWD*XLEN-1:0] fwd_data,
  input  logic [N_FWD-1:0]      fwd_ready,
  input  logic [XLEN-1:0]       rf_rdata,
  output logic [XLEN-1:0]       value,
  output logic                  hit,
  output logic                  not_ready
);

  logic [N_FWD-1:0] w_match;

  // Register 0 is hardwired; an unused operand must neither forward nor stall.
  for (genvar gi = 0; gi < N_FWD; gi++) begin : g_match
    assign w_match[gi] = fwd_valid[gi] && (fwd_rdc[gi*RA_W +: RA_W] == addr) &&
                         (addr != '0) && used;
  end

  // Scan oldest to youngest so the last assignment belongs to the youngest
  // matching source; only that source's ready bit decides the interlock.
  always_comb begin
    value     = rf_rdata;
    hit       = 1'b0;
    not_ready = 1'b0;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        value     = fwd_data[i*XLEN +: XLEN];
        hit       = 1'b1;
        not_ready = !fwd_ready[i];
      end
    end
  end

endmodule : fwd_select
`default_nettype wire

// File: rtl/id_stage_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_stage_fwd                                               |
// | Description : Instruction-decode pipe stage. Holds the IF->ID register,  |
// |               drives the register-file read addresses, resolves rs/rt    |
// |               through an N-source forwarding network and interlocks on   |
// |               sources whose data is not yet available.                   |
// | Ports:                                                                   |
// |   clk, rst            : clock, asynchronous active-high reset            |
// |   bus (slave)         : IF/EXE handshake, ID payload, forwarding bus     |
// |   flush               : kill the instruction held in ID                  |
// |   dec_rs/rt_used      : operand-use flags from the external decoder      |
// |   rf_raddr1/2, rf_rdata1/2 : register-file read port                     |
// |   rs_val, rt_val, eq_flag : resolved operands and their equality         |
// |   stall, stall_cnt    : hazard indication and saturating stall counter   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_stage_fwd
  import id_pkg::*;
#(
  parameter int XLEN  = c_XLEN,
  parameter int RA_W  = c_RA_W,
  parameter int N_FWD = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_fwd_if.slave    bus,
  input  logic             flush,
  input  logic             dec_rs_used,
  input  logic             dec_rt_used,
  output logic [RA_W-1:0]  rf_raddr1,
  output logic [RA_W-1:0]  rf_raddr2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  rs_val,
  output logic [XLEN-1:0]  rt_val,
  output logic             eq_flag,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic                 r_id_valid;
  logic [XLEN-1:0]      r_pc;
  logic [c_INSTR_W-1:0] r_instr;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic w_rs_hit, w_rs_not_ready;
  logic w_rt_hit, w_rt_not_ready;
  logic w_hazard, w_ready_go, w_allowin;

  assign rf_raddr1 = r_instr[c_RS_LSB +: RA_W];
  assign rf_raddr2 = r_instr[c_RT_LSB +: RA_W];

  fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .N_FWD(N_FWD)) u_fwd_rs (
    .addr      (rf_raddr1),
    .used      (dec_rs_used),
    .fwd_valid (bus.fwd_valid),
    .fwd_rdc   (bus.fwd_rdc),
    .fwd_data  (bus.fwd_data),
    .fwd_ready (bus.fwd_ready),
    .rf_rdata  (rf_rdata1),
    .value     (rs_val),
    .hit       (w_rs_hit),
    .not_ready (w_rs_not_ready)
  );

  fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .N_FWD(N_FWD)) u_fwd_rt (
    .addr      (rf_raddr2),
    .used      (dec_rt_used),
    .fwd_valid (bus.fwd_valid),
    .fwd_rdc   (bus.fwd_rdc),
    .fwd_data  (bus.fwd_data),
    .fwd_ready (bus.fwd_ready),
    .rf_rdata  (rf_rdata2),
    .value     (rt_val),
    .hit       (w_rt_hit),
    .not_ready (w_rt_not_ready)
  );

  assign eq_flag = (rs_val == rt_val);

  // Gated by the registered valid so an async reset drops stall immediately.
  assign w_hazard   = r_id_valid && ((w_rs_hit && w_rs_not_ready) ||
                                     (w_rt_hit && w_rt_not_ready));
  assign w_ready_go = !w_hazard;
  assign w_allowin  = !r_id_valid || (w_ready_go && bus.exe_allowin) || flush;

  assign stall              = w_hazard;
  assign bus.id_allowin     = w_allowin;
  assign bus.id_exe_validto = r_id_valid && w_ready_go && !flush;
  assign bus.id_valid       = r_id_valid;
  assign bus.pc_out         = r_pc;
  assign bus.instr_out      = r_instr;
  assign stall_cnt          = r_stall_cnt;

  // Pipeline register. Flush wins over a new instruction; a payload arriving
  // in the flush cycle is captured but its valid bit is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_pc       <= '0;
      r_instr    <= '0;
    end else begin
      if (flush) begin
        r_id_valid <= 1'b0;
      end else if (w_allowin) begin
        r_id_valid <= bus.if_id_validto;
      end
      if ((flush || w_allowin) && bus.if_id_validto) begin
        r_pc    <= bus.pc_in;
        r_instr <= bus.instr_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule : id_stage_fwd
`default_nettype wire

// File: tb/tb_id_stage_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_stage_fwd                                            |
// | Description : Self-checking bench for id_stage_fwd: a table of operand   |
// |               resolution vectors plus directed multi-cycle sequences     |
// |               (load-use stall, flush, backpressure, saturation, reset).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_stage_fwd;

  localparam int c_XLEN  = 32;
  localparam int c_RA_W  = 5;
  localparam int c_N_FWD = 3;
  localparam int c_CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic dec_rs_used = 1'b1;
  logic dec_rt_used = 1'b1;
  logic [c_RA_W-1:0]  rf_raddr1, rf_raddr2;
  logic [c_XLEN-1:0]  rf_rdata1 = '0, rf_rdata2 = '0;
  logic [c_XLEN-1:0]  rs_val, rt_val;
  logic               eq_flag, stall;
  logic [c_CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  id_stage_fwd_if #(.XLEN(c_XLEN), .RA_W(c_RA_W), .N_FWD(c_N_FWD)) bus ();

  id_stage_fwd #(.XLEN(c_XLEN), .RA_W(c_RA_W), .N_FWD(c_N_FWD), .CNT_W(c_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .dec_rs_used (dec_rs_used),
    .dec_rt_used (dec_rt_used),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .eq_flag     (eq_flag),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  used;   // {rs_used, rt_used}
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [2:0]  fv;
    logic [2:0]  fr;
    logic [14:0] rdc;
    logic [95:0] data;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic        exp_eq;
    logic        exp_stall;
  } vec_t;

  localparam int c_NVEC = 11;
  vec_t vecs [c_NVEC];

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] used,
                               input logic [31:0] rf1, input logic [31:0] rf2,
                               input logic [2:0] fv, input logic [2:0] fr,
                               input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                               input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                               input logic [31:0] ers, input logic [31:0] ert,
                               input logic eeq, input logic est);
    vec_t v;
    v.rs = rs; v.rt = rt; v.used = used; v.rf1 = rf1; v.rf2 = rf2;
    v.fv = fv; v.fr = fr; v.rdc = {a2, a1, a0}; v.data = {d2, d1, d0};
    v.exp_rs = ers; v.exp_rt = ert; v.exp_eq = eeq; v.exp_stall = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load one instruction into ID with the forwarding bus quiet, then leave
  // IF idle and EXE blocked so the instruction stays resident.
  task automatic load_instr(input logic [31:0] pc, input logic [31:0] ins);
    bus.fwd_valid     = '0;
    bus.exe_allowin   = 1'b1;
    bus.if_id_validto = 1'b1;
    bus.pc_in         = pc;
    bus.instr_in      = ins;
    flush             = 1'b0;
    @(posedge clk); #1;
    bus.if_id_validto = 1'b0;
    bus.exe_allowin   = 1'b0;
  endtask

  task automatic set_fwd(input logic [2:0] fv, input logic [2:0] fr,
                         input logic [14:0] rdc, input logic [95:0] data);
    bus.fwd_valid = fv;
    bus.fwd_ready = fr;
    bus.fwd_rdc   = rdc;
    bus.fwd_data  = data;
  endtask

  initial begin
    //                rs rt used rf1      rf2      fv      fr      a2 a1 a0 d2       d1       d0       exp_rs   exp_rt   eq stall
    vecs[0]  = mkv(1, 2, 2'b11, 32'h11,  32'h11,  3'b000, 3'b111, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h11,  32'h11,  1, 0);
    vecs[1]  = mkv(5, 6, 2'b11, 32'h100, 32'h200, 3'b101, 3'b111, 5, 0, 5, 32'hC,   32'h0,   32'hA,   32'hA,   32'h200, 0, 0);
    vecs[2]  = mkv(5, 6, 2'b11, 32'h100, 32'h200, 3'b100, 3'b111, 5, 0, 5, 32'hC,   32'h0,   32'hA,   32'hC,   32'h200, 0, 0);
    vecs[3]  = mkv(5, 6, 2'b11, 32'h100, 32'h200, 3'b001, 3'b110, 0, 0, 5, 32'h0,   32'h0,   32'hA,   32'hA,   32'h200, 0, 1);
    vecs[4]  = mkv(5, 6, 2'b11, 32'h100, 32'h200, 3'b011, 3'b101, 0, 5, 5, 32'h0,   32'hB,   32'hA,   32'hA,   32'h200, 0, 0);
    vecs[5]  = mkv(0, 6, 2'b11, 32'h0,   32'h200, 3'b001, 3'b000, 0, 0, 0, 32'h0,   32'h0,   32'hDEAD, 32'h0,  32'h200, 0, 0);
    vecs[6]  = mkv(5, 6, 2'b10, 32'h100, 32'h200, 3'b010, 3'b111, 0, 6, 0, 32'h0,   32'h77,  32'h0,   32'h100, 32'h200, 0, 0);
    vecs[7]  = mkv(5, 6, 2'b10, 32'h100, 32'h200, 3'b010, 3'b000, 0, 6, 0, 32'h0,   32'h77,  32'h0,   32'h100, 32'h200, 0, 0);
    vecs[8]  = mkv(1, 6, 2'b11, 32'h55,  32'h200, 3'b100, 3'b111, 6, 0, 0, 32'h55,  32'h0,   32'h0,   32'h55,  32'h55,  1, 0);
    vecs[9]  = mkv(1, 6, 2'b11, 32'h55,  32'h200, 3'b010, 3'b000, 0, 6, 0, 32'h0,   32'h77,  32'h0,   32'h55,  32'h77,  0, 1);
    vecs[10] = mkv(5, 5, 2'b11, 32'h1,   32'h2,   3'b010, 3'b010, 0, 5, 0, 32'h0,   32'h33,  32'h0,   32'h33,  32'h33,  1, 0);

    bus.if_id_validto = 1'b0;
    bus.pc_in         = '0;
    bus.instr_in      = '0;
    bus.exe_allowin   = 1'b1;
    set_fwd(3'b000, 3'b111, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid",  bus.id_valid,   0);
    chk("rst_pc_out",    bus.pc_out,     0);
    chk("rst_instr_out", bus.instr_out,  0);
    chk("rst_stall_cnt", stall_cnt,      0);
    chk("rst_allowin",   bus.id_allowin, 1);
    chk("rst_stall",     stall,          0);
    rst = 1'b0;

    // Load-use stall held for two cycles, then released
    load_instr(32'h200, mk(5, 2, 3));
    chk("lu_id_valid", bus.id_valid,  1);
    chk("lu_pc_out",   bus.pc_out,    32'h200);
    chk("lu_instr",    bus.instr_out, mk(5, 2, 3));
    dec_rs_used = 1'b1; dec_rt_used = 1'b1;
    rf_rdata1 = 32'h11; rf_rdata2 = 32'h11;
    set_fwd(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hA});
    bus.exe_allowin   = 1'b1;
    bus.if_id_validto = 1'b1;
    bus.pc_in         = 32'h204;
    bus.instr_in      = mk(1, 2, 3);
    #1;
    chk("lu_stall_c0",   stall,              1);
    chk("lu_allowin_c0", bus.id_allowin,     0);
    chk("lu_validto_c0", bus.id_exe_validto, 0);
    @(posedge clk); #1;
    chk("lu_stall_c1",   stall,              1);
    chk("lu_validto_c1", bus.id_exe_validto, 0);
    chk("lu_pc_hold",    bus.pc_out,         32'h200);
    @(posedge clk); #1;
    chk("lu_stall_cnt2", stall_cnt,          2);
    chk("lu_pc_hold2",   bus.pc_out,         32'h200);
    bus.fwd_ready = 3'b001;
    #1;
    chk("lu_rel_stall",   stall,              0);
    chk("lu_rel_validto", bus.id_exe_validto, 1);
    chk("lu_rel_allowin", bus.id_allowin,     1);
    chk("lu_rel_rs",      rs_val,             32'hA);
    @(posedge clk); #1;
    bus.if_id_validto = 1'b0;
    chk("lu_next_pc",  bus.pc_out, 32'h204);
    chk("lu_cnt_hold", stall_cnt,  2);

    // Basic flow: add $3,$1,$2 with no matching source
    #1;
    chk("bf_validto", bus.id_exe_validto, 1);
    chk("bf_rs",      rs_val,             32'h11);
    chk("bf_eq",      eq_flag,            1);
    chk("bf_stall",   stall,              0);

    // Flush during a hazard stall
    load_instr(32'h300, mk(5, 6, 7));
    set_fwd(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hA});
    bus.exe_allowin = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_stall",   stall,              1);
    chk("fl_validto", bus.id_exe_validto, 0);
    chk("fl_allowin", bus.id_allowin,     1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_id_valid", bus.id_valid, 0);
    chk("fl_stall_after", stall,     0);
    chk("fl_pc_hold", bus.pc_out,    32'h300);
    chk("fl_cnt",     stall_cnt,     3);

    // Backpressure: EXE blocked, IF offers a new instruction
    load_instr(32'h400, mk(1, 2, 3));
    bus.if_id_validto = 1'b1;
    bus.pc_in         = 32'h404;
    bus.instr_in      = mk(4, 4, 4);
    #1;
    chk("bp_allowin", bus.id_allowin,     0);
    chk("bp_validto", bus.id_exe_validto, 1);
    @(posedge clk); #1;
    bus.if_id_validto = 1'b0;
    chk("bp_pc_hold",    bus.pc_out,    32'h400);
    chk("bp_instr_hold", bus.instr_out, mk(1, 2, 3));
    chk("bp_id_valid",   bus.id_valid,  1);

    // Operand-resolution table
    for (int i = 0; i < c_NVEC; i++) begin
      load_instr(32'h1000 + 32'(i * 4), mk(vecs[i].rs, vecs[i].rt, 5'd9));
      dec_rs_used = vecs[i].used[1];
      dec_rt_used = vecs[i].used[0];
      rf_rdata1   = vecs[i].rf1;
      rf_rdata2   = vecs[i].rf2;
      set_fwd(vecs[i].fv, vecs[i].fr, vecs[i].rdc, vecs[i].data);
      #1;
      chk($sformatf("v%0d_raddr1", i),  rf_raddr1,          vecs[i].rs);
      chk($sformatf("v%0d_raddr2", i),  rf_raddr2,          vecs[i].rt);
      chk($sformatf("v%0d_rs_val", i),  rs_val,             vecs[i].exp_rs);
      chk($sformatf("v%0d_rt_val", i),  rt_val,             vecs[i].exp_rt);
      chk($sformatf("v%0d_eq", i),      eq_flag,            vecs[i].exp_eq);
      chk($sformatf("v%0d_stall", i),   stall,              vecs[i].exp_stall);
      chk($sformatf("v%0d_validto", i), bus.id_exe_validto, !vecs[i].exp_stall);
    end
    dec_rs_used = 1'b1;
    dec_rt_used = 1'b1;

    // Counter saturation (4-bit counter, starting from 3)
    load_instr(32'h500, mk(5, 6, 7));
    chk("sat_cnt_start", stall_cnt, 3);
    set_fwd(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hA});
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt",   stall_cnt, 15);
    chk("sat_stall", stall,     1);

    // Asynchronous reset mid-cycle, no clock edge before the check
    #1;
    rst = 1'b1;
    #1;
    chk("arst_id_valid",  bus.id_valid, 0);
    chk("arst_stall",     stall,        0);
    chk("arst_stall_cnt", stall_cnt,    0);
    chk("arst_pc_out",    bus.pc_out,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_id_stage_fwd
`default_nettype wire

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised successor to the instruction-decode pipe stage.
- Holds the IF→ID pipeline register and drives the register-file read ports.
- Resolves operands through a generic N-source forwarding network, with youngest source taking priority.
- Generalises the single load-use stall into per-source "data not yet ready" interlocks.
- Adds a flush input and a stall-cycle counter. Decoding proper (the cu block) stays outside; it consumes instr_out and returns operand-use flags.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- N_FWD, 3, number of forwarding sources; index 0 is youngest (EXE), N_FWD-1 is oldest (WB).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_id_validto  in  1  IF holds a valid instruction
- pc_in  in  XLEN  PC from IF
- instr_in  in  32  instruction from IF
- exe_allowin  in  1  EXE can accept this cycle
- flush  in  1  kill the instruction held in ID (redirect/exception)
- dec_rs_used  in  1  decoder: instr_out reads rs
- dec_rt_used  in  1  decoder: instr_out reads rt
- rf_raddr1  out  RA_W  rs field, instr_out[25:21]
- rf_raddr2  out  RA_W  rt field, instr_out[20:16]
- rf_rdata1  in  XLEN  regfile read data 1
- rf_rdata2  in  XLEN  regfile read data 2
- fwd_valid  in  N_FWD  source i holds a valid writing instruction
- fwd_rdc  in  N_FWD*RA_W  destination of source i, packed (slice i = [i*RA_W +: RA_W])
- fwd_data  in  N_FWD*XLEN  result of source i, packed
- fwd_ready  in  N_FWD  source i's data is available now (0 = load in flight)
- id_allowin  out  1  ID accepts from IF
- id_exe_validto  out  1  ID presents a valid instruction to EXE
- id_valid  out  1  ID stage occupied
- pc_out  out  XLEN  registered PC
- instr_out  out  32  registered instruction
- rs_val  out  XLEN  forwarded rs operand
- rt_val  out  XLEN  forwarded rt operand
- eq_flag  out  1  rs_val == rt_val
- stall  out  1  hazard stall active this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- Reset values: id_valid=0, pc_out=0, instr_out=0, stall_cnt=0. All combinational outputs follow from these.
- Operand match, per operand op ∈ {rs, rt}:
  - match_i = fwd_valid[i] && fwd_rdc_i==addr_op && addr_op!=0 && used_op.
  - Sel = lowest i with match_i.
  - No match: value = rf_rdata.
  - Match: value = fwd_data[Sel].
  - Register 0 never forwards and never stalls.
- hazard = id_valid && OR over operands of (match exists && !fwd_ready[Sel]).
  - Only the selected (youngest) match is checked. An older not-ready match shadowed by a younger ready one does not stall.
- stall = hazard. ready_go = !hazard.
- id_exe_validto = id_valid && ready_go && !flush.
- id_allowin = !id_valid || (ready_go && exe_allowin) || flush.
- Register update on each clk edge:
  - flush=1: id_valid <= 0. Payload is loaded only if if_id_validto is high; the loaded instruction is still discarded.
  - else if id_allowin: id_valid <= if_id_validto. pc_out/instr_out load only when if_id_validto=1; they hold otherwise.
  - else: hold everything.
- Flush has priority over the incoming instruction. IF is responsible for not asserting if_id_validto during a redirect cycle.
- Fully combinational operand path: zero-cycle latency from fwd_* to rs_val/rt_val/eq_flag.
- Outputs rs_val, rt_val and eq_flag are don't-care when id_valid=0.
- stall_cnt increments by 1 on every cycle with stall=1 and saturates at all-ones. Only rst clears it.
- Reset mid-stall: id_valid clears immediately (async), and stall deasserts in the same instant.

Decomposition:
- Shared package id_pkg: RA_W, XLEN defaults, and instruction field offsets (RS_LSB=21, RT_LSB=16).
- One sub-module: fwd_select (one instance per operand).
  - Inputs: address, use flag, packed fwd_* buses, regfile data.
  - Outputs: operand value, hit, not-ready.
  - Built as a priority scan over N_FWD.

Test Plan:
- Basic flow:
  - Stimulus: N_FWD=3, no matches, rf_rdata1=0x11, rf_rdata2=0x11, instr add $3,$1,$2 accepted, exe_allowin=1.
  - Response: next cycle id_exe_validto=1, rs_val=0x11, eq_flag=1, stall=0.
- Priority:
  - Stimulus: rs=$5, sources 0 and 2 both target $5, data 0xA / 0xC, all ready.
  - Response: rs_val=0xA.
  - Then drop fwd_valid[0]: rs_val=0xC.
- Load-use stall:
  - Stimulus: source 0 targets $5, fwd_ready[0]=0, rs used, held 2 cycles, exe_allowin=1.
  - Response: stall=1, id_allowin=0, id_exe_validto=0 for 2 cycles, stall_cnt=2.
  - Then raise fwd_ready[0]: instruction issues the same cycle.
- Zero register and use flags:
  - Stimulus: rs=$0 matched by a not-ready source; separately rt matched but dec_rt_used=0.
  - Response: no stall, values taken from rf_rdata.
- Flush:
  - Stimulus: flush=1 during a hazard stall, if_id_validto=0.
  - Response: that cycle id_exe_validto=0 and id_allowin=1; next cycle id_valid=0.
- Backpressure and async reset:
  - Stimulus: exe_allowin=0 with valid ID, new if_id_validto=1.
  - Response: pc_out/instr_out unchanged, id_allowin=0.
  - Stimulus: assert rst mid-cycle.
  - Response: id_valid=0 and stall_cnt=0 immediately, without waiting for a clk edge.
